// File: rtl/mem_request_arbiter.sv
// rtl/mem_request_arbiter.sv - single-port RAM arbiter between instruction fetch and data memory requesters
// Optional feature macro: ARB_STARVE_GUARD_EN (forces an instruction grant after STARVE_LIMIT data grants)
`timescale 1ns/1ps

module mem_request_arbiter #(
    parameter int TIMEOUT      = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        ihit,
    output logic        dhit,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    output logic        mem_err
);

    typedef enum logic [1:0] {
        RAM_FREE   = 2'd0,
        RAM_BUSY   = 2'd1,
        RAM_ACCESS = 2'd2,
        RAM_ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam int          WCW      = $clog2(TIMEOUT + 1);
    localparam logic [31:0] BAD_WORD = 32'hBAD1BAD1;

    // Reject configurations where a zero limit would make the counters meaningless.
    if (TIMEOUT < 1 || STARVE_LIMIT < 1) begin : g_bad_params
        $error("mem_request_arbiter: TIMEOUT and STARVE_LIMIT must both be at least 1");
    end

    state_t          state;
    logic            is_write;
    logic            withdrawn;
    logic [WCW-1:0]  wait_cnt;
    logic [WCW-1:0]  wait_inc;
    logic            data_req;
    logic            grant_i;
    logic            grant_d;
    logic            starve_force;
    logic            access_done;
    logic            access_fail;
    logic            timed_out;

    assign data_req = dREN | dWEN;

    // Saturating next value of the wait counter; a failure fires on the cycle
    // that would make the count of non-ACCESS cycles reach TIMEOUT.
    assign wait_inc    = (wait_cnt == WCW'(TIMEOUT)) ? wait_cnt : wait_cnt + 1'b1;
    assign access_done = (ramstate == RAM_ACCESS);
    assign timed_out   = !access_done && (wait_inc == WCW'(TIMEOUT));
    assign access_fail = (ramstate == RAM_ERROR) || timed_out;

`ifdef ARB_STARVE_GUARD_EN
    localparam int SCW = $clog2(STARVE_LIMIT + 1);

    logic [SCW-1:0] starve_cnt;

    assign starve_force = (starve_cnt == SCW'(STARVE_LIMIT));

    // Count data grants that bypassed a pending fetch; any fetch grant resets the count.
    always_ff @(posedge CLK) begin
        if (RST) begin
            starve_cnt <= '0;
        end else if (grant_i) begin
            starve_cnt <= '0;
        end else if (grant_d && iREN) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    assign starve_force = 1'b0;
`endif

    // Grant decision in IDLE: data wins (older instruction) unless the starvation guard trips.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state == IDLE) begin
            if (iREN && starve_force) begin
                grant_i = 1'b1;
            end else if (data_req) begin
                grant_d = 1'b1;
            end else if (iREN) begin
                grant_i = 1'b1;
            end
        end
    end

    // Access sequencer: latch the winner, hold the RAM strobes until completion, then pulse the hit.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            ihit      <= 1'b0;
            dhit      <= 1'b0;
            iload     <= '0;
            dload     <= '0;
            ramREN    <= 1'b0;
            ramWEN    <= 1'b0;
            ramaddr   <= '0;
            ramstore  <= '0;
            mem_err   <= 1'b0;
            is_write  <= 1'b0;
            withdrawn <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            ihit <= 1'b0;
            dhit <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state     <= DACC;
                        ramaddr   <= daddr;
                        ramstore  <= dstore;
                        is_write  <= dWEN;
                        ramWEN    <= dWEN;
                        ramREN    <= ~dWEN;
                        withdrawn <= 1'b0;
                        wait_cnt  <= '0;
                    end else if (grant_i) begin
                        state     <= IACC;
                        ramaddr   <= iaddr;
                        is_write  <= 1'b0;
                        ramWEN    <= 1'b0;
                        ramREN    <= 1'b1;
                        withdrawn <= 1'b0;
                        wait_cnt  <= '0;
                    end
                end
                IACC: begin
                    if (!iREN) begin
                        withdrawn <= 1'b1;
                    end
                    if (access_done || access_fail) begin
                        if (access_done) begin
                            iload <= ramload;
                        end else begin
                            iload   <= BAD_WORD;
                            mem_err <= 1'b1;
                        end
                        // A fetch flushed at any point in the access completes silently.
                        ihit   <= iREN && !withdrawn;
                        ramREN <= 1'b0;
                        ramWEN <= 1'b0;
                        state  <= RESP;
                    end else begin
                        wait_cnt <= wait_inc;
                    end
                end
                DACC: begin
                    if (access_done || access_fail) begin
                        if (access_done) begin
                            if (!is_write) begin
                                dload <= ramload;
                            end
                        end else begin
                            dload   <= BAD_WORD;
                            mem_err <= 1'b1;
                        end
                        dhit   <= 1'b1;
                        ramREN <= 1'b0;
                        ramWEN <= 1'b0;
                        state  <= RESP;
                    end else begin
                        wait_cnt <= wait_inc;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_request_arbiter.sv
// tb/tb_mem_request_arbiter.sv - directed self-checking bench for mem_request_arbiter
`timescale 1ns/1ps

module tb_mem_request_arbiter;

    logic        CLK;
    logic        RST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        ihit;
    logic        dhit;
    logic [31:0] iload;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic        mem_err;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] ST_FREE   = 2'd0;
    localparam logic [1:0] ST_BUSY   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_ERROR  = 2'd3;

    mem_request_arbiter #(.TIMEOUT(16), .STARVE_LIMIT(4)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .ihit     (ihit),
        .dhit     (dhit),
        .iload    (iload),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .mem_err  (mem_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = ST_FREE;
        tick; tick;
        checks++; if ({ihit, dhit, ramREN, ramWEN, mem_err} !== 5'b0) begin errors++;
            $display("FAIL reset_flags: got %b expected 00000", {ihit, dhit, ramREN, ramWEN, mem_err}); end
        checks++; if (iload !== 32'h0) begin errors++; $display("FAIL reset_iload: got %h expected 0", iload); end
        checks++; if (dload !== 32'h0) begin errors++; $display("FAIL reset_dload: got %h expected 0", dload); end
        checks++; if (ramaddr !== 32'h0) begin errors++; $display("FAIL reset_ramaddr: got %h expected 0", ramaddr); end
        checks++; if (ramstore !== 32'h0) begin errors++; $display("FAIL reset_ramstore: got %h expected 0", ramstore); end
        RST = 1'b0;
        tick;
    endtask

    task automatic test_ifetch;
        iREN = 1'b1; iaddr = 32'h40; ramstate = ST_ACCESS; ramload = 32'h8C220004;
        tick;
        checks++; if (ramREN !== 1'b1) begin errors++; $display("FAIL ifetch_ren: got %b expected 1", ramREN); end
        checks++; if (ramaddr !== 32'h40) begin errors++; $display("FAIL ifetch_addr: got %h expected 00000040", ramaddr); end
        checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL ifetch_early_hit: got %b expected 0", ihit); end
        tick;
        checks++; if (ihit !== 1'b1) begin errors++; $display("FAIL ifetch_ihit: got %b expected 1", ihit); end
        checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL ifetch_ren_drop: got %b expected 0", ramREN); end
        checks++; if (iload !== 32'h8C220004) begin errors++; $display("FAIL ifetch_iload: got %h expected 8c220004", iload); end
        iREN = 1'b0;
        tick;
        checks++; if ({ihit, ramREN} !== 2'b00) begin errors++; $display("FAIL ifetch_after: got %b expected 00", {ihit, ramREN}); end
    endtask

    task automatic test_data_priority;
        iREN = 1'b1; iaddr = 32'h44; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF;
        ramstate = ST_ACCESS; ramload = 32'h11111111;
        tick;
        checks++; if ({ramWEN, ramREN} !== 2'b10) begin errors++; $display("FAIL prio_strobes: got %b expected 10", {ramWEN, ramREN}); end
        checks++; if (ramaddr !== 32'h100) begin errors++; $display("FAIL prio_addr: got %h expected 00000100", ramaddr); end
        checks++; if (ramstore !== 32'hDEADBEEF) begin errors++; $display("FAIL prio_store: got %h expected deadbeef", ramstore); end
        tick;
        checks++; if ({dhit, ihit} !== 2'b10) begin errors++; $display("FAIL prio_dhit: got %b expected 10", {dhit, ihit}); end
        checks++; if (dload !== 32'h0) begin errors++; $display("FAIL prio_write_dload: got %h expected 0", dload); end
        dWEN = 1'b0; ramload = 32'h22222222;
        tick;
        tick;
        checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h44) begin errors++;
            $display("FAIL prio_ifetch_grant: got ren=%b addr=%h expected ren=1 addr=00000044", ramREN, ramaddr); end
        tick;
        checks++; if (ihit !== 1'b1 || iload !== 32'h22222222) begin errors++;
            $display("FAIL prio_ihit: got hit=%b load=%h expected hit=1 load=22222222", ihit, iload); end
        iREN = 1'b0;
        tick;
    endtask

    task automatic test_wait_states;
        dREN = 1'b1; daddr = 32'h200; ramstate = ST_BUSY; ramload = 32'h33333333;
        tick;
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) tick;
            if (k == 4) ramstate = ST_ACCESS;
            checks++;
            if (dhit !== (k == 5)) begin errors++; $display("FAIL wait_dhit_c%0d: got %b expected %b", k, dhit, (k == 5)); end
        end
        checks++; if (dload !== 32'h33333333) begin errors++; $display("FAIL wait_dload: got %h expected 33333333", dload); end
        checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL wait_mem_err: got %b expected 0", mem_err); end
        dREN = 1'b0; ramstate = ST_FREE;
        tick;
    endtask

    task automatic test_timeout;
        dREN = 1'b1; daddr = 32'h300; ramstate = ST_BUSY; ramload = 32'h55555555;
        tick;
        for (int k = 1; k <= 17; k++) begin
            if (k > 1) tick;
            checks++;
            if (dhit !== (k == 17)) begin errors++; $display("FAIL timeout_dhit_c%0d: got %b expected %b", k, dhit, (k == 17)); end
        end
        checks++; if (dload !== 32'hBAD1BAD1) begin errors++; $display("FAIL timeout_dload: got %h expected bad1bad1", dload); end
        checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL timeout_mem_err: got %b expected 1", mem_err); end
        dREN = 1'b0; ramstate = ST_ACCESS;
        tick; tick;
        checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b expected 1", mem_err); end
        RST = 1'b1;
        tick;
        RST = 1'b0;
        checks++; if (mem_err !== 1'b0 || dload !== 32'h0) begin errors++;
            $display("FAIL timeout_rst_clear: got err=%b dload=%h expected err=0 dload=0", mem_err, dload); end
        iREN = 1'b1; iaddr = 32'h700; ramstate = ST_ERROR;
        tick;
        tick;
        checks++; if (ihit !== 1'b1 || iload !== 32'hBAD1BAD1 || mem_err !== 1'b1) begin errors++;
            $display("FAIL error_resp: got hit=%b load=%h err=%b expected hit=1 load=bad1bad1 err=1", ihit, iload, mem_err); end
        iREN = 1'b0; ramstate = ST_FREE;
        tick;
    endtask

    task automatic test_withdraw;
        iREN = 1'b1; iaddr = 32'h80; ramstate = ST_BUSY; ramload = 32'h44444444;
        tick;
        iREN = 1'b0;
        tick;
        ramstate = ST_ACCESS;
        tick;
        checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL withdraw_no_ihit: got %b expected 0", ihit); end
        checks++; if (iload !== 32'h44444444) begin errors++; $display("FAIL withdraw_iload: got %h expected 44444444", iload); end
        tick;
        checks++; if ({ihit, ramREN} !== 2'b00) begin errors++; $display("FAIL withdraw_idle: got %b expected 00", {ihit, ramREN}); end
        dREN = 1'b1; daddr = 32'h88;
        tick;
        checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h88) begin errors++;
            $display("FAIL withdraw_next_grant: got ren=%b addr=%h expected ren=1 addr=00000088", ramREN, ramaddr); end
        tick;
        dREN = 1'b0;
        tick;
    endtask

    task automatic test_arbitration;
        string got;
        string exp;
        int    grants;
`ifdef ARB_STARVE_GUARD_EN
        exp = "DDDDIDDDDI";
`else
        exp = "DDDDDDDDDD";
`endif
        RST = 1'b1;
        tick;
        RST = 1'b0;
        dREN = 1'b1; dWEN = 1'b0; iREN = 1'b1; daddr = 32'h500; iaddr = 32'h600;
        ramstate = ST_ACCESS; ramload = 32'h66666666;
        got = "";
        grants = 0;
        for (int c = 0; c < 40 && grants < 10; c++) begin
            tick;
            if (ramREN === 1'b1 || ramWEN === 1'b1) begin
                if (ramaddr === 32'h600) got = {got, "I"};
                else got = {got, "D"};
                grants++;
            end
        end
        dREN = 1'b0; iREN = 1'b0;
        checks++; if (got != exp) begin errors++; $display("FAIL arb_sequence: got %s expected %s", got, exp); end
        tick; tick; tick;
    endtask

    initial begin
        test_reset;
        test_ifetch;
        test_data_priority;
        test_wait_states;
        test_timeout;
        test_withdraw;
        test_arbitration;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
